unidade_escrita: RTL and testbench

- Write-back sequencer for the 8-bit nrisc datapath. It is the writer side of the register bank's write port.
- Accepts results from the ALU or memory stage through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into the bank as a register write or a boolean-flag write.
- Provides a hazard/bypass lookup so decode can stall on, or forward, a pending write.

---
 rtl/unidade_escrita_if.sv | 43 ++++
 rtl/unidade_escrita.sv | 111 +++++++++++
 tb/tb_unidade_escrita.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/unidade_escrita_if.sv
// unidade_escrita_if
// Groups the three signal sets of the write-back sequencer:
//   - result side    : ResValido/ResReg/ResDado/ResBool in, ResPronto back
//   - bank write side: EscEn/EscReg/EscDado/EscBool, Pendente
//   - hazard lookup  : ConsultaReg/ConsultaBool in, Conflito/ConsultaDado back
// modport slave  : the sequencer itself
// modport master : whoever drives results and lookups (pipeline / testbench)
interface unidade_escrita_if #(
  parameter int LARG = 8
);
  logic            ResValido;
  logic [2:0]      ResReg;
  logic [LARG-1:0] ResDado;
  logic            ResBool;
  logic            ResPronto;

  logic            EscEn;
  logic [2:0]      EscReg;
  logic [LARG-1:0] EscDado;
  logic            EscBool;
  logic            Pendente;

  logic [2:0]      ConsultaReg;
  logic            ConsultaBool;
  logic            Conflito;
  logic [LARG-1:0] ConsultaDado;

  modport slave (
    input  ResValido, ResReg, ResDado, ResBool,
    output ResPronto,
    output EscEn, EscReg, EscDado, EscBool, Pendente,
    input  ConsultaReg, ConsultaBool,
    output Conflito, ConsultaDado
  );

  modport master (
    output ResValido, ResReg, ResDado, ResBool,
    input  ResPronto,
    input  EscEn, EscReg, EscDado, EscBool, Pendente,
    output ConsultaReg, ConsultaBool,
    input  Conflito, ConsultaDado
  );
endinterface

// File: rtl/unidade_escrita.sv
// unidade_escrita
// Write-back sequencer for the nrisc register bank write port. Results are
// queued in a PROF-deep FIFO and drained one per cycle into the bank (register
// or boolean bank). A combinational lookup tells decode whether a queued write
// targets a given index and forwards the youngest such value.
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - asynchronous, active-high; discards all queued entries
//   Halt   - freezes draining (pushes still accepted)
//   bus    - unidade_escrita_if.slave (result, bank write, lookup signals)
module unidade_escrita #(
  parameter int PROF = 4,
  parameter int LARG = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Halt,
  unidade_escrita_if.slave    bus
);

  localparam int AW = (PROF > 2) ? $clog2(PROF) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0]   ptr_esc;
  logic [AW-1:0]   ptr_lei;
  logic [CW-1:0]   cnt;

  logic            ent_bool [PROF];
  logic [2:0]      ent_reg  [PROF];
  logic [LARG-1:0] ent_dado [PROF];

  logic            cheio;
  logic            vazio;
  logic            push;
  logic            pop;

  // Bool entries are normalised on entry so that the head outputs and the
  // forwarded lookup data both already show what the bank will receive.
  logic [2:0]      norm_reg;
  logic [LARG-1:0] norm_dado;

  assign cheio = (cnt == CW'(PROF));
  assign vazio = (cnt == '0);

  // Refused when full even if the head leaves on the same edge.
  assign push  = bus.ResValido && !cheio;
  assign pop   = !vazio && !Halt;

  assign norm_reg  = bus.ResBool ? {1'b0, bus.ResReg[1:0]} : bus.ResReg;
  assign norm_dado = bus.ResBool ? {{(LARG-1){1'b0}}, bus.ResDado[0]} : bus.ResDado;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr_esc <= '0;
      ptr_lei <= '0;
      cnt     <= '0;
    end else begin
      if (push) ptr_esc <= ptr_esc + 1'b1;
      if (pop)  ptr_lei <= ptr_lei + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset: validity comes from cnt/ptr_lei only.
  always_ff @(posedge Clock) begin
    if (push) begin
      ent_bool[ptr_esc] <= bus.ResBool;
      ent_reg[ptr_esc]  <= norm_reg;
      ent_dado[ptr_esc] <= norm_dado;
    end
  end

  assign bus.ResPronto = !cheio;
  assign bus.Pendente  = !vazio;
  assign bus.EscEn     = pop;
  assign bus.EscBool   = vazio ? 1'b0 : ent_bool[ptr_lei];
  assign bus.EscReg    = vazio ? 3'b000 : ent_reg[ptr_lei];
  assign bus.EscDado   = vazio ? '0 : ent_dado[ptr_lei];

  // Lookup walks oldest to youngest; the last hit wins, giving the youngest.
  logic            conf;
  logic [LARG-1:0] cdado;
  logic [AW-1:0]   idx;
  logic            igual;

  always_comb begin
    conf  = 1'b0;
    cdado = '0;
    idx   = '0;
    igual = 1'b0;
    for (int k = 0; k < PROF; k++) begin
      idx = ptr_lei + AW'(k);
      if (bus.ConsultaBool)
        igual = ent_bool[idx] && (ent_reg[idx][1:0] == bus.ConsultaReg[1:0]);
      else
        igual = !ent_bool[idx] && (ent_reg[idx] == bus.ConsultaReg);
      if ((CW'(k) < cnt) && igual) begin
        conf  = 1'b1;
        cdado = ent_dado[idx];
      end
    end
  end

  assign bus.Conflito     = conf;
  assign bus.ConsultaDado = cdado;

endmodule

// File: tb/tb_unidade_escrita.sv
module tb_unidade_escrita;
  localparam int PROF = 4;
  localparam int LARG = 8;

  logic Clock = 1'b0;
  logic Reset;
  logic Halt;

  unidade_escrita_if #(.LARG(LARG)) bus ();

  unidade_escrita #(.PROF(PROF), .LARG(LARG)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Halt  (Halt),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit       b;
    bit [2:0] r;
    bit [7:0] d;
  } ent_t;

  ent_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  bit       cur_v, cur_b, cur_h;
  bit [2:0] cur_r;
  bit [7:0] cur_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // What the bank would receive for an entry.
  function automatic bit [2:0] wreg(ent_t e);
    return e.b ? {1'b0, e.r[1:0]} : e.r;
  endfunction
  function automatic bit [7:0] wdado(ent_t e);
    return e.b ? {7'b0, e.d[0]} : e.d;
  endfunction

  task automatic check_model();
    bit       pend, conf;
    bit [7:0] cd;
    bit [2:0] cr;
    bit       cb;
    pend = (q.size() != 0);
    chk("pronto",   bus.ResPronto, 32'(q.size() != PROF));
    chk("pendente", bus.Pendente,  32'(pend));
    chk("escen",    bus.EscEn,     32'(pend && !cur_h));
    chk("escbool",  bus.EscBool,   pend ? 32'(q[0].b) : 32'd0);
    chk("escreg",   bus.EscReg,    pend ? 32'(wreg(q[0])) : 32'd0);
    chk("escdado",  bus.EscDado,   pend ? 32'(wdado(q[0])) : 32'd0);
    cr = bus.ConsultaReg;
    cb = bus.ConsultaBool;
    conf = 1'b0;
    cd = 8'h00;
    foreach (q[i]) begin
      if (q[i].b == cb && (cb ? (q[i].r[1:0] == cr[1:0]) : (q[i].r == cr))) begin
        conf = 1'b1;
        cd   = wdado(q[i]);
      end
    end
    chk("conflito", bus.Conflito,     32'(conf));
    chk("cdado",    bus.ConsultaDado, 32'(cd));
  endtask

  task automatic set(input bit v, input bit [2:0] r, input bit [7:0] d, input bit b,
                     input bit h, input bit [2:0] cr, input bit cb);
    @(negedge Clock);
    cur_v = v; cur_r = r; cur_d = d; cur_b = b; cur_h = h;
    bus.ResValido    = v;
    bus.ResReg       = r;
    bus.ResDado      = d;
    bus.ResBool      = b;
    Halt             = h;
    bus.ConsultaReg  = cr;
    bus.ConsultaBool = cb;
    #1;
    check_model();
  endtask

  task automatic tick();
    bit do_pop, do_push;
    ent_t e;
    do_pop  = (q.size() != 0) && !cur_h;
    do_push = cur_v && (q.size() != PROF);
    @(posedge Clock);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.b = cur_b; e.r = cur_r; e.d = cur_d;
      q.push_back(e);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Halt = 1'b0;
    cur_h = 1'b0;
    bus.ResValido = 1'b0; bus.ResReg = '0; bus.ResDado = '0; bus.ResBool = 1'b0;
    bus.ConsultaReg = '0; bus.ConsultaBool = 1'b0;
    #3;
    check_model();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // single push, one cycle latency
    set(1, 3'd3, 8'hA5, 0, 0, 3'd3, 0);
    tick();
    set(0, 0, 0, 0, 0, 3'd3, 0);
    chk("t1_en", bus.EscEn, 1);
    chk("t1_reg", bus.EscReg, 3);
    chk("t1_dado", bus.EscDado, 8'hA5);
    tick();
    set(0, 0, 0, 0, 0, 0, 0);
    chk("t1_pend", bus.Pendente, 0);
    tick();

    // fill under Halt, refuse 5th, then drain in order
    for (int i = 1; i <= 4; i++) begin
      set(1, 3'(i), 8'(i), 0, 1, 0, 0);
      tick();
    end
    set(1, 3'd5, 8'h99, 0, 1, 0, 0);
    chk("t2_full", bus.ResPronto, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      set(0, 0, 0, 0, 0, 0, 0);
      chk("t2_en", bus.EscEn, 1);
      chk("t2_dado", bus.EscDado, 32'(i));
      tick();
    end
    set(0, 0, 0, 0, 0, 0, 0);
    chk("t2_empty", bus.Pendente, 0);
    tick();

    // steady stream
    for (int i = 0; i < 20; i++) begin
      set(1, 3'($urandom_range(7)), 8'($urandom), 0, 0, 3'($urandom_range(7)), 0);
      chk("t3_pronto", bus.ResPronto, 1);
      tick();
    end
    set(0, 0, 0, 0, 0, 0, 0);
    tick();

    // lookup returns youngest match
    set(1, 3'd5, 8'h10, 0, 1, 3'd5, 0); tick();
    set(1, 3'd5, 8'h20, 0, 1, 3'd5, 0); tick();
    set(0, 0, 0, 0, 1, 3'd5, 0);
    chk("t4_conf", bus.Conflito, 1);
    chk("t4_cdado", bus.ConsultaDado, 8'h20);
    tick();
    set(0, 0, 0, 0, 1, 3'd5, 1);
    chk("t4_conf_b", bus.Conflito, 0);
    chk("t4_cdado_b", bus.ConsultaDado, 0);
    tick();
    set(0, 0, 0, 0, 0, 3'd5, 0); tick();
    set(0, 0, 0, 0, 0, 3'd5, 0); tick();

    // boolean write masking
    set(1, 3'b110, 8'hFF, 1, 0, 3'b010, 1);
    tick();
    set(0, 0, 0, 0, 0, 3'b110, 1);
    chk("t5_bool", bus.EscBool, 1);
    chk("t5_reg", bus.EscReg, 3'b010);
    chk("t5_dado", bus.EscDado, 8'h01);
    chk("t5_conf", bus.Conflito, 1);
    tick();

    // async reset mid-drain
    for (int i = 0; i < 3; i++) begin
      set(1, 3'(i + 1), 8'(8'h30 + i), 0, 1, 0, 0);
      tick();
    end
    set(0, 0, 0, 0, 0, 0, 0);
    #2;
    Reset = 1'b1;
    #1;
    chk("t6_en", bus.EscEn, 0);
    chk("t6_pend", bus.Pendente, 0);
    chk("t6_pronto", bus.ResPronto, 1);
    q.delete();
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0);
    chk("t6_nowrite", bus.EscEn, 0);
    tick();
    set(1, 3'd7, 8'h5C, 0, 0, 0, 0);
    tick();
    set(0, 0, 0, 0, 0, 0, 0);
    chk("t6_after", bus.EscDado, 8'h5C);
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set(($urandom_range(99) < 70), 3'($urandom_range(7)), 8'($urandom),
          ($urandom_range(3) == 0), ($urandom_range(3) == 0),
          3'($urandom_range(7)), ($urandom_range(3) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
